// File: rtl/jtag_pkg.sv
// Shared types, widths and helpers for the JTAG vector player.
//   state_t      : sequencer states
//   jtag_pins_t  : registered TCK/TMS/TDI pin bundle
//   step_bits_t  : one {tdi,tms} step field out of a vector byte
//   step_field() : extracts step k (0..3) from a vector byte
package jtag_pkg;

  localparam int unsigned STEP_W      = 15;
  localparam int unsigned BYTE_ADDR_W = 12;
  localparam int unsigned HALF_W      = 16;
  localparam int unsigned BIT_CNT_W   = 4;
  localparam int unsigned LAT_W       = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_HIGH,
    ST_WRITE
  } state_t;

  typedef struct packed {
    logic tck;
    logic tms;
    logic tdi;
  } jtag_pins_t;

  typedef struct packed {
    logic tdi;
    logic tms;
  } step_bits_t;

  // Step k of a vector byte lives at bits [2k+1:2k] as {tdi,tms}.
  function automatic step_bits_t step_field(input logic [7:0] vec, input logic [1:0] k);
    step_bits_t f;
    f = step_bits_t'(vec[{k, 1'b0} +: 2]);
    return f;
  endfunction

endpackage

// File: rtl/jtag_vector_player_tck_timer.sv
// Loadable down counter timing one TCK half-period (SETUP or HIGH phase).
//   clk, reset_n : clock, async active-low reset
//   load         : load load_val on this edge
//   load_val     : half-period length in clk cycles (>= 1)
//   expire_c     : current cycle is the last one of the phase
module tck_timer
  import jtag_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [HALF_W-1:0] load_val,
  output logic              expire_c
);

  logic [HALF_W-1:0] count_q;

  // Count holds the number of cycles left in the phase, including this one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - HALF_W'(1);
    end
  end

  assign expire_c = (count_q <= HALF_W'(1));

endmodule

// File: rtl/jtag_vector_player.sv
// Plays a stored JTAG vector from vector RAM 1 onto TCK/TMS/TDI and packs
// the sampled TDO bits into bytes written to vector RAM 2.
//   clk, reset_n          : vector RAM clock, async active-low reset
//   start, abort          : one-cycle run / stop requests (abort wins)
//   step_count, tck_half  : run length in TCK cycles, TCK half-period (sampled at start)
//   vector_1_addr/rd_data : vector fetch port, data valid RD_LAT clocks after address
//   vector_2_addr/we/wr_data : capture write port
//   jtag_tck/tms/tdi/tdo  : JTAG pins (tdo already synchronised)
//   busy, done            : run in progress, one-cycle completion pulse
module jtag_vector_player
  import jtag_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [STEP_W-1:0]      step_count,
  input  logic [HALF_W-1:0]      tck_half,
  output logic [BYTE_ADDR_W-1:0] vector_1_addr,
  input  logic [7:0]             vector_1_rd_data,
  output logic [BYTE_ADDR_W-1:0] vector_2_addr,
  output logic                   vector_2_we,
  output logic [7:0]             vector_2_wr_data,
  output logic                   jtag_tck,
  output logic                   jtag_tms,
  output logic                   jtag_tdi,
  input  logic                   jtag_tdo,
  output logic                   busy,
  output logic                   done
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

  state_t                 state_q, state_d;
  logic [STEP_W-1:0]      idx_q, idx_d, idx_inc;
  logic [STEP_W-1:0]      n_q, n_d;
  logic [HALF_W-1:0]      half_q, half_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [7:0]             byte_q, byte_d;
  logic [7:0]             cap_q, cap_d;
  logic [BIT_CNT_W-1:0]   bitc_q, bitc_d;
  logic [BYTE_ADDR_W-1:0] bytec_q, bytec_d;
  logic [BYTE_ADDR_W-1:0] v1_addr_q, v1_addr_d;
  logic [BYTE_ADDR_W-1:0] v2_addr_q, v2_addr_d;
  logic                   v2_we_q, v2_we_d;
  logic [7:0]             v2_data_q, v2_data_d;
  jtag_pins_t             pins_q, pins_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timer_load;
  logic                   timer_expire_c;
  step_bits_t             fld_c;

  tck_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (half_q),
    .expire_c (timer_expire_c)
  );

  // Next-state, datapath and output computation.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    half_d     = half_q;
    lat_d      = lat_q;
    byte_d     = byte_q;
    cap_d      = cap_q;
    bitc_d     = bitc_q;
    bytec_d    = bytec_q;
    v1_addr_d  = v1_addr_q;
    v2_addr_d  = v2_addr_q;
    v2_data_d  = v2_data_q;
    v2_we_d    = 1'b0;
    done_d     = 1'b0;
    pins_d     = pins_q;
    busy_d     = 1'b0;
    timer_load = 1'b0;
    idx_inc    = idx_q + STEP_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (step_count != '0) begin
            n_d     = step_count;
            half_d  = (tck_half == '0) ? HALF_W'(1) : tck_half;
            idx_d   = '0;
            cap_d   = '0;
            bitc_d  = '0;
            bytec_d = '0;
            state_d = ST_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        if (lat_q == '0) begin
          byte_d  = vector_1_rd_data;
          state_d = ST_SETUP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      // TDO is sampled on the edge that raises TCK.
      ST_SETUP: begin
        if (timer_expire_c) begin
          cap_d   = cap_q | (8'(jtag_tdo) << bitc_q);
          bitc_d  = bitc_q + BIT_CNT_W'(1);
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (timer_expire_c) begin
          idx_d = idx_inc;
          if ((bitc_q == BIT_CNT_W'(8)) || (idx_inc == n_q)) begin
            state_d   = ST_WRITE;
            v2_we_d   = 1'b1;
            v2_addr_d = bytec_q;
            v2_data_d = cap_q;
          end else if (idx_inc[1:0] == 2'd0) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end

      // idx_q already points at the step after the one just captured.
      ST_WRITE: begin
        bytec_d = bytec_q + BYTE_ADDR_W'(1);
        cap_d   = '0;
        bitc_d  = '0;
        if (idx_q == n_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (idx_q[1:0] == 2'd0) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_SETUP;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      v2_we_d = 1'b0;
    end

    // Entry actions keyed on the state being entered.
    if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
      v1_addr_d = idx_d[BYTE_ADDR_W+1:2];
      lat_d     = LAT_LOAD;
    end

    if (((state_d == ST_SETUP) || (state_d == ST_HIGH)) && (state_d != state_q)) begin
      timer_load = 1'b1;
    end

    // New TMS/TDI are presented together with the TCK falling edge.
    fld_c = step_field(byte_d, idx_d[1:0]);
    if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
      pins_d.tms = fld_c.tms;
      pins_d.tdi = fld_c.tdi;
    end

    // TCK stays high across a mid-run fetch so it only falls on SETUP/WRITE entry.
    pins_d.tck = (state_d == ST_HIGH) || ((state_d == ST_FETCH) && pins_q.tck);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      half_q    <= HALF_W'(1);
      lat_q     <= '0;
      byte_q    <= '0;
      cap_q     <= '0;
      bitc_q    <= '0;
      bytec_q   <= '0;
      v1_addr_q <= '0;
      v2_addr_q <= '0;
      v2_we_q   <= 1'b0;
      v2_data_q <= '0;
      pins_q    <= '{tck: 1'b0, tms: 1'b1, tdi: 1'b0};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      half_q    <= half_d;
      lat_q     <= lat_d;
      byte_q    <= byte_d;
      cap_q     <= cap_d;
      bitc_q    <= bitc_d;
      bytec_q   <= bytec_d;
      v1_addr_q <= v1_addr_d;
      v2_addr_q <= v2_addr_d;
      v2_we_q   <= v2_we_d;
      v2_data_q <= v2_data_d;
      pins_q    <= pins_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign vector_1_addr    = v1_addr_q;
  assign vector_2_addr    = v2_addr_q;
  assign vector_2_we      = v2_we_q;
  assign vector_2_wr_data = v2_data_q;
  assign jtag_tck         = pins_q.tck;
  assign jtag_tms         = pins_q.tms;
  assign jtag_tdi         = pins_q.tdi;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_jtag_vector_player.sv
// Bench for jtag_vector_player: three instances (RD_LAT = 1, 2, 3) share a
// vector RAM 1 image; one is selected per test. A monitor pops expected
// writes and expected per-step pin values from queues as the DUT produces them.
module tb_jtag_vector_player;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic [11:0] addr;
    logic        tms;
    logic        tdi;
  } pin_t;

  typedef struct {
    int s;
    int n;
    int h;
    int mode;
    int exp_busy;
  } row_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [14:0] step_count = '0;
  logic [15:0] tck_half = '0;
  logic        tdo;
  logic [1:0]  sel = 2'd1;
  logic [1:0]  tdo_mode = 2'd1;

  logic [2:0]       tck_v, tms_v, tdi_v, we_v, busy_v, done_v;
  logic [2:0][11:0] v1a_v, v2a_v;
  logic [2:0][7:0]  v2d_v;
  logic [7:0]       rd_v [3];
  logic [7:0]       v1_mem [4096];

  logic        s_tck, s_tms, s_tdi, s_we, s_busy, s_done;
  logic [11:0] s_v1a, s_v2a;
  logic [7:0]  s_v2d;

  wr_t  exp_w[$];
  pin_t exp_p[$];

  int checks = 0;
  int errors = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  int cyc = 0;
  int last_rise = 0;
  int cur_h = 1;
  bit mon_en = 1'b0;
  logic prev_tck = 1'b0;
  logic prev_we = 1'b0;

  always #5 clk = ~clk;

  // Target model: constant TDO, or 1,0,1,0... advancing on each TCK rise.
  assign tdo = (tdo_mode == 2'd2) ? ~rise_cnt[0] : tdo_mode[0];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] p1, p2;
    always @(posedge clk) begin
      p1 <= v1_mem[v1a_v[g]];
      p2 <= p1;
    end
    assign rd_v[g] = (g == 0) ? v1_mem[v1a_v[g]] : ((g == 1) ? p1 : p2);

    jtag_vector_player #(.RD_LAT(g + 1)) u_dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start && (sel == 2'(g))),
      .abort            (abort && (sel == 2'(g))),
      .step_count       (step_count),
      .tck_half         (tck_half),
      .vector_1_addr    (v1a_v[g]),
      .vector_1_rd_data (rd_v[g]),
      .vector_2_addr    (v2a_v[g]),
      .vector_2_we      (we_v[g]),
      .vector_2_wr_data (v2d_v[g]),
      .jtag_tck         (tck_v[g]),
      .jtag_tms         (tms_v[g]),
      .jtag_tdi         (tdi_v[g]),
      .jtag_tdo         (tdo),
      .busy             (busy_v[g]),
      .done             (done_v[g])
    );
  end

  always_comb begin
    s_tck  = tck_v[sel];
    s_tms  = tms_v[sel];
    s_tdi  = tdi_v[sel];
    s_we   = we_v[sel];
    s_busy = busy_v[sel];
    s_done = done_v[sel];
    s_v1a  = v1a_v[sel];
    s_v2a  = v2a_v[sel];
    s_v2d  = v2d_v[sel];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops on writes and TCK rises, plus cycle counters.
  always @(negedge clk) begin
    logic rise;
    wr_t  w;
    pin_t p;
    cyc++;
    rise = s_tck && !prev_tck;
    prev_tck = s_tck;
    if (!mon_en) begin
      rise_cnt = 0;
      prev_we  = 1'b0;
    end else begin
      if (s_busy) busy_cyc++;
      if (s_done) begin
        done_cnt++;
        check("done_with_busy_low", 32'(s_busy), 0);
      end
      if (s_we) begin
        check("we_not_back_to_back", 32'(prev_we), 0);
        check("write_expected", 32'(exp_w.size() > 0), 1);
        if (exp_w.size() > 0) begin
          w = exp_w.pop_front();
          check("wr_addr", 32'(s_v2a), 32'(w.addr));
          check("wr_data", 32'(s_v2d), 32'(w.data));
        end
      end
      prev_we = s_we;
      if (rise) begin
        if ((rise_cnt % 4) != 0) check("tck_period", 32'(cyc - last_rise), 32'(2 * cur_h));
        last_rise = cyc;
        rise_cnt++;
        check("step_expected", 32'(exp_p.size() > 0), 1);
        if (exp_p.size() > 0) begin
          p = exp_p.pop_front();
          check("step_addr_tms_tdi", 32'({s_v1a, s_tms, s_tdi}), 32'({p.addr, p.tms, p.tdi}));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Build expectations for the first 'play' steps; writes only for complete runs.
  task automatic prep(input int s, input int n, input int h, input int mode,
                      input int play, input bit wr);
    sel      = 2'(s);
    tdo_mode = 2'(mode);
    cur_h    = (h == 0) ? 1 : h;
    exp_w.delete();
    exp_p.delete();
    for (int k = 0; k < play; k++) begin
      logic [7:0] b;
      pin_t p;
      b      = v1_mem[k / 4];
      p.addr = 12'(k / 4);
      p.tms  = b[2 * (k % 4)];
      p.tdi  = b[2 * (k % 4) + 1];
      exp_p.push_back(p);
    end
    if (wr) begin
      for (int bi = 0; bi < (n + 7) / 8; bi++) begin
        wr_t w;
        w.addr = 12'(bi);
        w.data = '0;
        for (int j = 0; j < 8; j++) begin
          if (8 * bi + j < n) w.data[j] = (mode == 2) ? ((j % 2) == 0) : (mode == 1);
        end
        exp_w.push_back(w);
      end
    end
    busy_cyc = 0;
    done_cnt = 0;
    mon_en   = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input int n, input int h);
    step_count = 15'(n);
    tck_half   = 16'(h);
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(s_busy), (n > 0) ? 1 : 0);
  endtask

  task automatic wait_done(input int limit);
    int t;
    t = 0;
    while (done_cnt == 0 && t < limit) begin
      tick();
      t++;
    end
  endtask

  task automatic end_checks(input int exp_busy, input int exp_done);
    check("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
    check("done_pulses", 32'(done_cnt), 32'(exp_done));
    check("writes_outstanding", 32'(exp_w.size()), 0);
    check("steps_outstanding", 32'(exp_p.size()), 0);
    mon_en = 1'b0;
    abort  = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic run_row(input row_t r);
    prep(r.s, r.n, r.h, r.mode, r.n, 1'b1);
    pulse_start(r.n, r.h);
    wait_done(3000);
    repeat (3) tick();
    end_checks(r.exp_busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t rows[7];
    int   t;
    // {instance (0:RD_LAT1 1:RD_LAT2 2:RD_LAT3), N, tck_half, tdo mode, busy cycles}
    rows[0] = '{1, 4, 1, 1, 11};
    rows[1] = '{1, 16, 3, 2, 106};
    rows[2] = '{1, 0, 5, 1, 0};
    rows[3] = '{0, 9, 0, 1, 23};
    rows[4] = '{2, 9, 0, 1, 29};
    rows[5] = '{1, 13, 2, 2, 62};
    rows[6] = '{1, 8, 1, 0, 21};

    for (int i = 0; i < 4096; i++) v1_mem[i] = 8'($urandom);
    v1_mem[0] = 8'b10_01_11_00;

    repeat (3) tick();
    for (int g = 0; g < 3; g++) begin
      check("rst_tck", 32'(tck_v[g]), 0);
      check("rst_tms", 32'(tms_v[g]), 1);
      check("rst_tdi", 32'(tdi_v[g]), 0);
      check("rst_busy_done_we", 32'({busy_v[g], done_v[g], we_v[g]}), 0);
      check("rst_addrs_data", 32'({v1a_v[g], v2a_v[g], v2d_v[g]}), 0);
    end
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_row(rows[i]);

    // Abort during HIGH of step 5: no write, no done, TCK and busy drop next cycle.
    prep(1, 16, 2, 1, 6, 1'b0);
    pulse_start(16, 2);
    t = 0;
    while (rise_cnt < 6 && t < 500) begin
      tick();
      t++;
    end
    check("abort_in_high", 32'(s_tck), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_tck_low", 32'(s_tck), 0);
    check("abort_busy_low", 32'(s_busy), 0);
    repeat (4) tick();
    end_checks(27, 0);
    run_row(rows[0]);

    // start+abort together in IDLE, then a second start while busy: both ignored.
    prep(1, 4, 2, 1, 4, 1'b1);
    step_count = 15'd8;
    tck_half   = 16'd2;
    start      = 1'b1;
    abort      = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_ignored", 32'(s_busy), 0);
    pulse_start(4, 2);
    repeat (4) tick();
    step_count = 15'd12;
    tck_half   = 16'd1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000);
    repeat (3) tick();
    end_checks(19, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_vector_player.md
# jtag_vector_player

Sequencer that plays a stored JTAG vector out of vector RAM 1 onto the TCK/TMS/TDI pins and captures TDO into vector RAM 2. It sits in the main unit next to the vector RAMs and drives their fabric-side ports on the vector RAM clock. The CPU loads vectors and calibration values, pulses a start, polls busy/done, then reads the captured TDO bytes back.

## Interface
Parameters:
- RD_LAT, 2, vector_1 read latency in clocks, from address presented to data valid; legal 1..3.

Ports:
- clk  in  1  vector RAM clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; ignored while busy.
- abort  in  1  one-cycle stop request; wins over start.
- step_count  in  15  number of TCK cycles to play, 0..16384; sampled at start.
- tck_half  in  16  TCK half-period in clk cycles; 0 treated as 1; sampled at start.
- vector_1_addr  out  12  byte address into vector RAM 1.
- vector_1_rd_data  in  8  vector byte: step k of the byte is {tdi,tms} at bits [2k+1:2k], k=0..3.
- vector_2_addr  out  12  byte address into vector RAM 2.
- vector_2_we  out  1  one-cycle write strobe.
- vector_2_wr_data  out  8  captured TDO byte, LSB = earliest step.
- jtag_tck  out  1  JTAG clock.
- jtag_tms  out  1  JTAG mode select.
- jtag_tdi  out  1  JTAG data to target.
- jtag_tdo  in  1  JTAG data from target; already synchronised by the caller.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, FETCH, SETUP, HIGH, WRITE.
- IDLE: start with step_count>0 -> latch step_count and tck_half, step index 0, vector_1_addr 0, go FETCH. start with step_count=0 -> done pulse next cycle, busy stays low.
- FETCH: entered when step index mod 4 = 0. Hold vector_1_addr = index/4 for RD_LAT cycles, latch the byte, go SETUP.
- SETUP: tck=0, tms/tdi = field (index mod 4) of the latched byte, for tck_half cycles, go HIGH.
- HIGH: tck=1 for tck_half cycles. TDO is shifted into the capture register on the first HIGH cycle, at the TCK rising edge.
- End of HIGH, in priority order: 8 bits captured or last step -> WRITE. Otherwise, next index mod 4 = 0 -> FETCH. Otherwise -> SETUP.
- WRITE: tck=0. One cycle with vector_2_we=1, vector_2_addr = captured-byte count, data = capture register. A partial final byte is zero-filled in the upper bits. Byte count increments and the capture register clears. Then: last step -> IDLE with a done pulse; next index mod 4 = 0 -> FETCH; else -> SETUP.
- abort in any state: IDLE on the next edge. tck forced 0, partial byte not written, no done pulse.
- tms and tdi hold their last driven values in IDLE.
- Counters: step index 15 bits; byte count 12 bits (max 2048 bytes); half-period counter 16 bits, down-counting.

## Timing
- Reset values: jtag_tck 0, jtag_tms 1, jtag_tdi 0, busy 0, done 0, vector_2_we 0, vector_1_addr 0, vector_2_addr 0, vector_2_wr_data 0; state IDLE.
- busy rises on the cycle after start is sampled and falls in the same cycle done pulses.
- For H = max(tck_half,1) and N steps, busy is high for exactly ceil(N/4)·RD_LAT + 2·N·H + ceil(N/8) cycles.
- The TCK falling edge coincides with entry to SETUP or WRITE. tms/tdi change only on the TCK falling edge.
- vector_2_we is never asserted two cycles in a row.

## Structure
- Shared package jtag_pkg holds: state enum, STEP_W=15, BYTE_ADDR_W=12, HALF_W=16, and the field-extract function for {tdi,tms}.
- Sub-module tck_timer: loadable 16-bit down counter with an expire flag, reused for the SETUP and HIGH phases.

## Test plan
- N=4, H=1, vector_1[0]=8'b10_01_11_00, TDO held 1 -> TMS/TDI sequence {0,0},{1,1},{1,0},{0,1}; one write to addr 0 with data 8'h0F; busy for 2+8+1=11 cycles.
- N=16, H=3, TDO = alternating 1,0 from a target model -> vector_2[0]=vector_2[1]=8'h55; TCK period 6 clk cycles; four FETCHes at addresses 0..3.
- N=0 with start -> done in the next cycle, busy never high, no RAM access.
- abort during HIGH of step 5 (N=16) -> tck=0 and busy=0 on the next cycle; no write at addr 0; no done pulse. A new start then runs normally from address 0.
- start while busy, and start+abort in the same cycle -> both ignored; step_count latched from the first start unchanged.
- RD_LAT=1 and RD_LAT=3 builds, N=9, H=0 -> behaves as H=1; writes to addr 0 (8 bits) and addr 1 (1 bit, upper 7 bits zero).
